btn_event_scheduler: RTL and testbench

//  Turns N debounced button levels into press events (SHORT/LONG/REPEAT): one per-button

---
 rtl/btn_evt_pkg.sv | 11 +
 rtl/btn_press_fsm.sv | 64 ++++++
 rtl/btn_event_scheduler.sv | 86 ++++++++
 tb/tb_btn_event_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: event codes, press FSM states and pending-slot type shared by the button event scheduler
package btn_evt_pkg;
  localparam logic [1:0] EVT_SHORT  = 2'd0;
  localparam logic [1:0] EVT_LONG   = 2'd1;
  localparam logic [1:0] EVT_REPEAT = 2'd2;
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  typedef struct packed {
    logic       full;
    logic [1:0] typ;
  } slot_t;
endpackage

// File: rtl/btn_press_fsm.sv
// btn_press_fsm: per-button press FSM posting SHORT/LONG (and REPEAT when BTN_EVT_REPEAT_EN) events
module btn_press_fsm
  import btn_evt_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       lvl,
  output logic       post,
  output logic [1:0] post_type,
  output logic       held
);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // release is checked before tick so it wins a same-cycle tie
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    post      = 1'b0;
    post_type = EVT_SHORT;
    case (state)
      IDLE: if (lvl) begin
        state_n = PRESSED;
        cnt_n   = '0;
      end
      PRESSED: if (!lvl) begin
        post    = 1'b1;
        state_n = IDLE;
      end else if (tick) begin
        if (cnt == 16'(LONG_MS - 1)) begin
          post      = 1'b1;
          post_type = EVT_LONG;
          state_n   = HELD;
          cnt_n     = '0;
        end else cnt_n = &cnt ? cnt : cnt + 16'd1;
      end
      HELD: begin
        if (!lvl) state_n = IDLE;
`ifdef BTN_EVT_REPEAT_EN
        else if (tick) begin
          if (cnt == 16'(REPEAT_MS - 1)) begin
            post      = 1'b1;
            post_type = EVT_REPEAT;
            cnt_n     = '0;
          end else cnt_n = &cnt ? cnt : cnt + 16'd1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  assign held = state == HELD;
endmodule

// File: rtl/btn_event_scheduler.sv
// btn_event_scheduler: press FSMs, pending slots and round-robin valid/ready event port
// Optional REPEAT events are built when BTN_EVT_REPEAT_EN is defined.
module btn_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         i_btn_lvl,
  output logic                     o_evt_valid,
  input  logic                     i_evt_ready,
  output logic [$clog2(N_BTN)-1:0] o_evt_id,
  output logic [1:0]               o_evt_type,
  output logic                     o_evt_drop,
  output logic [N_BTN-1:0]         o_btn_held
);
  localparam int IW  = $clog2(N_BTN);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = DIV > 1 ? $clog2(DIV) : 1;
  logic [TW-1:0] tcnt;
  logic tick;
  assign tick = tcnt == TW'(DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;
  logic [N_BTN-1:0] post;
  logic [1:0] post_type [N_BTN];
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_press_fsm #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .lvl      (i_btn_lvl[g]),
      .post     (post[g]),
      .post_type(post_type[g]),
      .held     (o_btn_held[g])
    );
  end
  slot_t slot [N_BTN];
  logic [IW-1:0] rr, win;
  logic found, load, drop_n;
  logic [N_BTN-1:0] clr, full;
  assign load = !o_evt_valid || i_evt_ready;
  // lowest offset from rr wins, so scan offsets from high to low
  always_comb begin
    found = 1'b0;
    win   = rr;
    for (int k = N_BTN - 1; k >= 0; k--)
      if (slot[(int'(rr) + k) % N_BTN].full) begin
        found = 1'b1;
        win   = IW'((int'(rr) + k) % N_BTN);
      end
    for (int i = 0; i < N_BTN; i++) begin
      full[i] = slot[i].full;
      clr[i]  = load && found && win == IW'(i);
    end
    drop_n = |(post & full & ~clr);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) slot[i] <= '0;
      rr          <= '0;
      o_evt_valid <= 1'b0;
      o_evt_id    <= '0;
      o_evt_type  <= EVT_SHORT;
      o_evt_drop  <= 1'b0;
    end else begin
      o_evt_drop <= drop_n;
      for (int i = 0; i < N_BTN; i++)
        if (post[i] && (!full[i] || clr[i])) slot[i] <= '{full: 1'b1, typ: post_type[i]};
        else if (clr[i]) slot[i].full <= 1'b0;
      if (load) begin
        o_evt_valid <= found;
        if (found) begin
          o_evt_id   <= win;
          o_evt_type <= slot[win].typ;
          rr         <= IW'((int'(win) + 1) % N_BTN);
        end
      end
    end
endmodule

// File: tb/tb_btn_event_scheduler.sv
// tb_btn_event_scheduler: age-based press model plus slot/arbiter scoreboard, with directed literal checks
module tb_btn_event_scheduler;
  localparam int N = 4, L = 10, R = 4;
  localparam bit REP =
`ifdef BTN_EVT_REPEAT_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, ready = 1'b1;
  logic [N-1:0] btn = '0;
  logic valid, drop;
  logic [1:0] id, ty;
  logic [N-1:0] held;
  int checks = 0, errors = 0, cyc_n = 0, drops = 0;
  int acc_id[$], acc_ty[$], acc_cyc[$];
  always #5 clk = ~clk;
  btn_event_scheduler #(.N_BTN(N), .CLK_HZ(1000), .TICK_HZ(1000), .LONG_MS(L), .REPEAT_MS(R)) dut (
    .clk(clk), .reset(reset), .i_btn_lvl(btn), .o_evt_valid(valid), .i_evt_ready(ready),
    .o_evt_id(id), .o_evt_type(ty), .o_evt_drop(drop), .o_btn_held(held));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // model: events derive from edge count since the press began
  bit mpress[N], mfull[N], pv[N], mv, mdrop, ld, dn;
  int mage[N], mtyp[N], pt[N], mid, mty, mrr, w, wt, idx;
  always @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < N; i++) begin mpress[i] = 0; mfull[i] = 0; mage[i] = 0; mtyp[i] = 0; end
      mv = 0; mdrop = 0; mid = 0; mty = 0; mrr = 0;
    end else begin
      cyc_n++;
      for (int i = 0; i < N; i++) begin
        pv[i] = 0; pt[i] = 0;
        if (!mpress[i]) begin
          if (btn[i]) begin mpress[i] = 1; mage[i] = 0; end
        end else begin
          mage[i]++;
          if (!btn[i]) begin
            mpress[i] = 0;
            if (mage[i] <= L) begin pv[i] = 1; pt[i] = 0; end
          end else if (mage[i] == L) begin pv[i] = 1; pt[i] = 1; end
          else if (REP && mage[i] > L && (mage[i] - L) % R == 0) begin pv[i] = 1; pt[i] = 2; end
        end
      end
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mrr + k) % N;
        if (w < 0 && mfull[idx]) w = idx;
      end
      wt = w >= 0 ? mtyp[w] : 0;
      ld = !mv || ready;
      dn = 0;
      for (int i = 0; i < N; i++)
        if (pv[i]) begin
          if (!mfull[i] || (ld && w == i)) begin mfull[i] = 1; mtyp[i] = pt[i]; end
          else dn = 1;
        end else if (ld && w == i) mfull[i] = 0;
      if (ld) begin
        mv = w >= 0;
        if (w >= 0) begin mid = w; mty = wt; mrr = (w + 1) % N; end
      end
      mdrop = dn;
    end
  always @(negedge clk)
    if (!reset) begin
      chk("valid", int'(valid), int'(mv));
      if (mv) begin
        chk("id", int'(id), mid);
        chk("type", int'(ty), mty);
      end
      chk("drop", int'(drop), int'(mdrop));
      for (int i = 0; i < N; i++) chk("held", int'(held[i]), int'(mpress[i] && mage[i] >= L));
      if (valid && ready) begin
        acc_id.push_back(int'(id)); acc_ty.push_back(int'(ty)); acc_cyc.push_back(cyc_n);
      end
      if (drop) drops++;
    end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1; btn = '0; ready = 1'b1;
    cyc(2);
    reset = 1'b0;
    acc_id.delete(); acc_ty.delete(); acc_cyc.delete(); drops = 0;
  endtask
  task automatic tap(input int b, input int n);
    btn[b] = 1'b1; cyc(n);
    btn[b] = 1'b0; cyc(2);
  endtask
  initial begin
    do_reset();
    chk("reset_valid", int'(valid), 0);
    chk("reset_held", int'(held), 0);
    // 1: short press
    btn = 4'b0001; cyc(5); btn = '0; cyc(10);
    chk("t1_count", acc_id.size(), 1);
    if (acc_id.size() == 1) begin chk("t1_id", acc_id[0], 0); chk("t1_type", acc_ty[0], 0); end
    // 2: long hold
    do_reset();
    btn = 4'b0010; cyc(20);
    chk("t2_held", int'(held), 2);
    btn = '0; cyc(3);
    chk("t2_held_fall", int'(held), 0);
    chk("t2_count", acc_id.size(), REP ? 3 : 1);
    if (acc_id.size() >= 1) begin chk("t2_id", acc_id[0], 1); chk("t2_type", acc_ty[0], 1); end
    if (REP && acc_id.size() == 3) begin
      chk("t2_rep1", acc_ty[1], 2); chk("t2_rep2", acc_ty[2], 2);
      chk("t2_rep_gap", acc_cyc[2] - acc_cyc[1], R);
    end
    // 3: simultaneous releases with backpressure
    do_reset();
    btn = 4'b1111; cyc(3);
    ready = 1'b0; btn = '0; cyc(2);
    for (int i = 0; i < 6; i++) begin
      chk("t3_hold_valid", int'(valid), 1); chk("t3_hold_id", int'(id), 0);
      cyc(1);
    end
    ready = 1'b1; cyc(6);
    chk("t3_count", acc_id.size(), 4);
    if (acc_id.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t3_order", acc_id[i], i);
        chk("t3_type", acc_ty[i], 0);
        if (i > 0) chk("t3_gap", acc_cyc[i] - acc_cyc[i-1], 1);
      end
    // 4: slot overflow drop
    do_reset();
    ready = 1'b0;
    tap(2, 2); tap(2, 2);
    chk("t4_no_drop_yet", drops, 0);
    tap(2, 2);
    chk("t4_drop", drops, 1);
    ready = 1'b1; cyc(6);
    chk("t4_count", acc_id.size(), 2);
    if (acc_id.size() == 2) begin
      chk("t4_id0", acc_id[0], 2); chk("t4_id1", acc_id[1], 2); chk("t4_ty", acc_ty[1], 0);
    end
    // 5: async reset mid-transfer
    do_reset();
    ready = 1'b0;
    tap(1, 2);
    btn = 4'b0010; cyc(4);
    chk("t5_pre_valid", int'(valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_valid", int'(valid), 0);
    chk("t5_rst_id", int'(id), 0);
    chk("t5_rst_type", int'(ty), 0);
    chk("t5_rst_drop", int'(drop), 0);
    chk("t5_rst_held", int'(held), 0);
    @(posedge clk); #1;
    reset = 1'b0; ready = 1'b1;
    acc_id.delete(); acc_ty.delete(); acc_cyc.delete();
    cyc(11);
    chk("t5_not_yet", int'(valid), 0);
    cyc(1);
    chk("t5_long_valid", int'(valid), 1);
    chk("t5_long_id", int'(id), 1);
    chk("t5_long_type", int'(ty), 1);
    btn = '0; cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
